t_integrator: RTL and testbench
===============================

T_INTEGRATOR -- requirements
Module: t_integrator

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, the width of every sample and accumulator word.
REQ-002 SHALL have parameter I, default 160, the number of samples per interval.
REQ-003 SHALL have parameter NU_VALUES, default 3, the number of parallel channels.
REQ-004 SHALL have parameter SEGMENTS, default 8, the number of intervals per run.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start_in, input, 1 bit: one-cycle pulse that begins a run.
REQ-008 SHALL have port nu_valid_in, input, 1 bit: nu_in holds a sample this cycle.
REQ-009 SHALL have port nu_in, input, [BIT_WIDTH-1:0] x [0:NU_VALUES-1]: one sample per channel.
REQ-010 SHALL have port T_vals, output, [BIT_WIDTH-1:0] x [0:NU_VALUES-1]: per-channel cumulative sums at the interval's right end.
REQ-011 SHALL have port output_start, output, 1 bit: one-cycle pulse marking the start of a run; drives the downstream phi stage input_start.
REQ-012 SHALL have port output_valid, output, 1 bit: one-cycle pulse; T_vals is valid this cycle; drives the downstream input_valid.
REQ-013 SHALL have port seg_idx, output, $clog2(SEGMENTS+1) bits: 1-based index of the interval that T_vals closes.
REQ-014 SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the last interval is emitted.

Function
REQ-016 SHALL implement states IDLE and RUN.
REQ-017 SHALL treat start_in in any state as a restart:
- clear accumulators, sample counter and segment counter;
- enter RUN;
- pulse output_start on the next cycle.
REQ-018 SHALL, in RUN, accept a sample only when nu_valid_in=1 and start_in=0; start_in takes priority and a simultaneous sample is dropped.
REQ-019 SHALL add each accepted nu_in[c] to acc[c] modulo 2^BIT_WIDTH (wrap, no saturation, unsigned).
REQ-020 SHALL count accepted samples 0..I-1.
REQ-021 SHALL handle the I-th accepted sample of an interval as follows, all on the next cycle:
- T_vals = acc including that sample;
- output_valid=1;
- seg_idx = completed interval count.
REQ-022 SHALL NOT clear accumulators between intervals, so T_vals is cumulative from run start.
REQ-023 SHALL have a latency of exactly 1 cycle from the closing sample to output_valid.
REQ-024 SHALL hold T_vals and seg_idx stable between output_valid pulses.
REQ-025 SHALL, on the SEGMENTS-th interval, pulse done together with output_valid and return to IDLE on the same edge.
REQ-026 SHALL ignore nu_valid_in in IDLE.
REQ-027 SHALL accept back-to-back samples at one per cycle with no stall; there is no backpressure.
REQ-028 SHALL never assert output_start and output_valid in the same cycle.

Reset
REQ-029 SHALL, while rst_in=1, force:
- state IDLE;
- acc, counters, T_vals and seg_idx to 0;
- output_start, output_valid, busy and done to 0.
REQ-030 SHALL let rst_in override start_in, and SHALL abandon a run if reset is asserted mid-run, emitting no further pulses.

Structure
REQ-031 SHALL take BIT_WIDTH, I, NU_VALUES, SEGMENTS and the state enum from a shared package phi_pkg, which is also used by the phi stage.
REQ-032 SHALL implement the per-channel wrap accumulator as a sub-module t_acc, instantiated NU_VALUES times.

Verification (bench with I=4, SEGMENTS=2, BIT_WIDTH=8, NU_VALUES=3)
REQ-033 SHALL cover a basic run:
- stimulus: start, then 8 consecutive samples nu={1,2,3};
- response: output_valid after sample 4 with T_vals={4,8,12}, seg_idx=1;
- response: after sample 8, T_vals={8,16,24}, seg_idx=2, done=1, busy falls.
REQ-034 SHALL cover gapped input: samples with nu_valid_in toggling every other cycle give the same T_vals, and each output_valid is exactly 1 cycle after its 4th accepted sample.
REQ-035 SHALL cover wrap: nu={100,0,255} x4 -> T_vals={144,0,252}.
REQ-036 SHALL cover restart:
- stimulus: start_in with a valid sample in the same cycle, at sample 2 of interval 2;
- response: that sample is dropped, output_start pulses, and the next interval closes with seg_idx=1 and fresh sums.
REQ-037 SHALL cover reset mid-run: rst_in asserted after 3 samples -> all outputs 0, and no output_valid even if 5 further samples arrive.
REQ-038 SHALL cover IDLE: samples with no start -> no output_valid, busy=0.

Source files
------------

// File: rtl/phi_pkg.sv
// Shared definitions for the T integrator and the downstream phi stage:
// default sizing and the run-control state encoding.
package phi_pkg;

    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_I         = 160;
    localparam int DEF_NU_VALUES = 3;
    localparam int DEF_SEGMENTS  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/t_integrator_if.sv
// Bundle of the integrator's sample-input and interval-output signals.
// The master drives samples and start; the slave (the integrator) returns sums.
interface t_integrator_if
    import phi_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NU_VALUES = DEF_NU_VALUES,
    parameter int SEGMENTS  = DEF_SEGMENTS
);
    logic                         start_in;
    logic                         nu_valid_in;
    logic [BIT_WIDTH-1:0]         nu_in  [0:NU_VALUES-1];
    logic [BIT_WIDTH-1:0]         T_vals [0:NU_VALUES-1];
    logic                         output_start;
    logic                         output_valid;
    logic [$clog2(SEGMENTS+1)-1:0] seg_idx;
    logic                         busy;
    logic                         done;

    modport master (
        output start_in, nu_valid_in, nu_in,
        input  T_vals, output_start, output_valid, seg_idx, busy, done
    );

    modport slave (
        input  start_in, nu_valid_in, nu_in,
        output T_vals, output_start, output_valid, seg_idx, busy, done
    );
endinterface

// File: rtl/t_acc.sv
// One channel of the run accumulator: unsigned, wraps modulo 2^BIT_WIDTH.
// o_sum_next already includes the sample on i_din so the caller can publish
// the interval total on the same edge that absorbs the closing sample.
module t_acc
    import phi_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [BIT_WIDTH-1:0] i_din,
    output logic [BIT_WIDTH-1:0] o_acc,
    output logic [BIT_WIDTH-1:0] o_sum_next
);
    logic [BIT_WIDTH-1:0] r_acc;

    assign o_sum_next = r_acc + i_din;
    assign o_acc      = r_acc;

    // Clear on reset or run restart, otherwise add each accepted sample.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum_next;
        end
    end
endmodule

// File: rtl/t_integrator.sv
// Per-channel running integrator. Sums I accepted samples per interval,
// publishes the cumulative sums at each interval end, and stops after
// SEGMENTS intervals. start_in restarts a run from any state.
module t_integrator
    import phi_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int I         = DEF_I,
    parameter int NU_VALUES = DEF_NU_VALUES,
    parameter int SEGMENTS  = DEF_SEGMENTS
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic                          nu_valid_in,
    input  logic [BIT_WIDTH-1:0]          nu_in  [0:NU_VALUES-1],
    output logic [BIT_WIDTH-1:0]          T_vals [0:NU_VALUES-1],
    output logic                          output_start,
    output logic                          output_valid,
    output logic [$clog2(SEGMENTS+1)-1:0] seg_idx,
    output logic                          busy,
    output logic                          done
);
    localparam int SAMP_W = (I > 1) ? $clog2(I) : 1;
    localparam int SEG_W  = $clog2(SEGMENTS+1);

    state_t              r_state;
    logic [SAMP_W-1:0]   r_samp;
    logic [SEG_W-1:0]    r_seg;

    logic                w_accept;
    logic                w_last_samp;
    logic                w_last_seg;
    logic [SEG_W-1:0]    w_seg_next;
    logic [BIT_WIDTH-1:0] w_acc [0:NU_VALUES-1];
    logic [BIT_WIDTH-1:0] w_sum [0:NU_VALUES-1];

    // start_in wins over a same-cycle sample, which is dropped.
    assign w_accept    = (r_state == ST_RUN) && nu_valid_in && !start_in;
    assign w_last_samp = (r_samp == SAMP_W'(I-1));
    assign w_seg_next  = r_seg + 1'b1;
    assign w_last_seg  = (w_seg_next == SEG_W'(SEGMENTS));

    genvar g;
    generate
        for (g = 0; g < NU_VALUES; g++) begin : g_ch
            t_acc #(.BIT_WIDTH(BIT_WIDTH)) u_acc (
                .i_clk      (clk_in),
                .i_rst      (rst_in),
                .i_clr      (start_in),
                .i_en       (w_accept),
                .i_din      (nu_in[g]),
                .o_acc      (w_acc[g]),
                .o_sum_next (w_sum[g])
            );
        end
    endgenerate

    // Run control: counters, state, and registered output pulses/data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_samp       <= '0;
            r_seg        <= '0;
            output_start <= 1'b0;
            output_valid <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            seg_idx      <= '0;
            for (int c = 0; c < NU_VALUES; c++) T_vals[c] <= '0;
        end else begin
            output_start <= 1'b0;
            output_valid <= 1'b0;
            done         <= 1'b0;
            if (start_in) begin
                r_state      <= ST_RUN;
                busy         <= 1'b1;
                r_samp       <= '0;
                r_seg        <= '0;
                output_start <= 1'b1;
            end else if (w_accept) begin
                if (w_last_samp) begin
                    r_samp       <= '0;
                    r_seg        <= w_seg_next;
                    seg_idx      <= w_seg_next;
                    output_valid <= 1'b1;
                    for (int c = 0; c < NU_VALUES; c++) T_vals[c] <= w_sum[c];
                    if (w_last_seg) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end else begin
                    r_samp <= r_samp + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_t_integrator.sv
// Scoreboard bench for t_integrator with I=4, SEGMENTS=2, 8-bit, 3 channels.
module tb_t_integrator;
    import phi_pkg::*;

    localparam int BW  = 8;
    localparam int II  = 4;
    localparam int NV  = 3;
    localparam int SEG = 2;

    typedef struct {
        logic [7:0] tv0, tv1, tv2;
        int         seg;
        bit         dn;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    t_integrator_if #(.BIT_WIDTH(BW), .NU_VALUES(NV), .SEGMENTS(SEG)) bus ();

    t_integrator #(.BIT_WIDTH(BW), .I(II), .NU_VALUES(NV), .SEGMENTS(SEG)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .start_in     (bus.start_in),
        .nu_valid_in  (bus.nu_valid_in),
        .nu_in        (bus.nu_in),
        .T_vals       (bus.T_vals),
        .output_start (bus.output_start),
        .output_valid (bus.output_valid),
        .seg_idx      (bus.seg_idx),
        .busy         (bus.busy),
        .done         (bus.done)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_cyc = 0;
    exp_t exp_q[$];

    // reference model state
    bit         m_run;
    logic [7:0] m_acc [3];
    int         m_cnt, m_seg;
    logic [7:0] m_tv [3];
    int         m_seg_out;
    logic [7:0] last_tv [3];
    int         last_seg;
    int         n_valid_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_seg = 0;
        for (int c = 0; c < 3; c++) m_acc[c] = 8'd0;
    endtask

    // Drive one cycle, advance the model, then check outputs after the edge.
    task automatic cyc(input bit r, input bit st, input bit v,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        bit   exp_start;
        exp_t e;
        rst             = r;
        bus.start_in    = st;
        bus.nu_valid_in = v;
        bus.nu_in[0]    = a;
        bus.nu_in[1]    = b;
        bus.nu_in[2]    = d;
        n_cyc++;
        exp_start = 1'b0;
        if (r) begin
            m_run = 1'b0;
            model_clear();
            for (int c = 0; c < 3; c++) m_tv[c] = 8'd0;
            m_seg_out = 0;
        end else if (st) begin
            m_run = 1'b1;
            model_clear();
            exp_start = 1'b1;
        end else if (m_run && v) begin
            m_acc[0] = m_acc[0] + a;
            m_acc[1] = m_acc[1] + b;
            m_acc[2] = m_acc[2] + d;
            m_cnt++;
            if (m_cnt == II) begin
                m_cnt = 0;
                m_seg++;
                for (int c = 0; c < 3; c++) m_tv[c] = m_acc[c];
                m_seg_out = m_seg;
                e.tv0 = m_acc[0]; e.tv1 = m_acc[1]; e.tv2 = m_acc[2];
                e.seg = m_seg; e.dn = (m_seg == SEG); e.cyc = n_cyc;
                exp_q.push_back(e);
                if (m_seg == SEG) m_run = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("output_start", 32'(bus.output_start), 32'(exp_start));
        check("busy", 32'(bus.busy), 32'(m_run));
        check("seg_idx", 32'(bus.seg_idx), 32'(m_seg_out));
        check("T_vals0", 32'(bus.T_vals[0]), 32'(m_tv[0]));
        check("T_vals1", 32'(bus.T_vals[1]), 32'(m_tv[1]));
        check("T_vals2", 32'(bus.T_vals[2]), 32'(m_tv[2]));
        if (bus.output_valid) begin
            n_valid_seen++;
            for (int c = 0; c < 3; c++) last_tv[c] = bus.T_vals[c];
            last_seg = 32'(bus.seg_idx);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("valid_latency_cyc", 32'(n_cyc), 32'(e.cyc));
                check("sb_T0", 32'(bus.T_vals[0]), 32'(e.tv0));
                check("sb_T1", 32'(bus.T_vals[1]), 32'(e.tv1));
                check("sb_T2", 32'(bus.T_vals[2]), 32'(e.tv2));
                check("sb_seg", 32'(bus.seg_idx), 32'(e.seg));
                check("sb_done", 32'(bus.done), 32'(e.dn));
            end
        end else begin
            check("done_without_valid", 32'(bus.done), 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bus.start_in    = 1'b0;
        bus.nu_valid_in = 1'b0;
        for (int c = 0; c < NV; c++) bus.nu_in[c] = '0;
        m_run = 1'b0; model_clear();
        for (int c = 0; c < 3; c++) begin m_tv[c] = 8'd0; last_tv[c] = 8'd0; end
        m_seg_out = 0; last_seg = 0; n_valid_seen = 0;

        // reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 9, 9, 9);
        check("rst_valid", 32'(bus.output_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        // IDLE: samples without start are ignored
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 1, 2, 3);
        check("idle_valid_count", 32'(n_valid_seen), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        drain("idle_queue_empty");

        // basic run
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 2, 3);
        check("basic1_T0", 32'(last_tv[0]), 32'd4);
        check("basic1_T1", 32'(last_tv[1]), 32'd8);
        check("basic1_T2", 32'(last_tv[2]), 32'd12);
        check("basic1_seg", 32'(last_seg), 32'd1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 2, 3);
        check("basic2_T0", 32'(last_tv[0]), 32'd8);
        check("basic2_T1", 32'(last_tv[1]), 32'd16);
        check("basic2_T2", 32'(last_tv[2]), 32'd24);
        check("basic2_seg", 32'(last_seg), 32'd2);
        check("basic2_done", 32'(bus.done), 32'd1);
        check("basic2_busy", 32'(bus.busy), 32'd0);
        cyc(0, 0, 1, 1, 2, 3);
        drain("basic_queue_empty");

        // gapped input
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) cyc(0, 0, (k % 2) == 0, 1, 2, 3);
        check("gap_T0", 32'(last_tv[0]), 32'd8);
        check("gap_T2", 32'(last_tv[2]), 32'd24);
        drain("gap_queue_empty");

        // wrap
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 100, 0, 255);
        check("wrap_T0", 32'(last_tv[0]), 32'd144);
        check("wrap_T1", 32'(last_tv[1]), 32'd0);
        check("wrap_T2", 32'(last_tv[2]), 32'd252);
        drain("wrap_queue_empty");

        // restart at sample 2 of interval 2, with a same-cycle sample
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 2, 3);
        cyc(0, 1, 1, 50, 50, 50);
        check("restart_start_pulse", 32'(bus.output_start), 32'd1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 2, 3);
        check("restart_T0", 32'(last_tv[0]), 32'd4);
        check("restart_T1", 32'(last_tv[1]), 32'd8);
        check("restart_T2", 32'(last_tv[2]), 32'd12);
        check("restart_seg", 32'(last_seg), 32'd1);
        drain("restart_queue_empty");

        // reset mid-run
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 7, 7, 7);
        n_valid_seen = 0;
        cyc(1, 0, 1, 7, 7, 7);
        check("midrst_T0", 32'(bus.T_vals[0]), 32'd0);
        check("midrst_seg", 32'(bus.seg_idx), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 7, 7, 7);
        check("midrst_no_valid", 32'(n_valid_seen), 32'd0);
        drain("midrst_queue_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
